// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/issue bundle for regfile_wb_arbiter; slave = arbiter side, master = requesters/issue.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [5*NUM_REQ-1:0]          i_req_rd;
  logic [`WORD_SIZE*NUM_REQ-1:0] i_req_wd;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_Wen;
  logic [4:0]                    o_Wnum;
  logic [`WORD_SIZE-1:0]         o_Wd;
  logic                          i_issue_en;
  logic [4:0]                    i_issue_rd;
  logic [4:0]                    i_rs1;
  logic [4:0]                    i_rs2;
  logic                          o_hazard;
`ifdef WB_BYPASS_EN
  logic                          o_fwd1_en;
  logic                          o_fwd2_en;
  logic [`WORD_SIZE-1:0]         o_fwd_data;

  modport slave (
    input  i_req_valid, i_req_rd, i_req_wd, i_issue_en, i_issue_rd, i_rs1, i_rs2,
    output o_req_ready, o_Wen, o_Wnum, o_Wd, o_hazard, o_fwd1_en, o_fwd2_en, o_fwd_data
  );

  modport master (
    output i_req_valid, i_req_rd, i_req_wd, i_issue_en, i_issue_rd, i_rs1, i_rs2,
    input  o_req_ready, o_Wen, o_Wnum, o_Wd, o_hazard, o_fwd1_en, o_fwd2_en, o_fwd_data
  );
`else
  modport slave (
    input  i_req_valid, i_req_rd, i_req_wd, i_issue_en, i_issue_rd, i_rs1, i_rs2,
    output o_req_ready, o_Wen, o_Wnum, o_Wd, o_hazard
  );

  modport master (
    output i_req_valid, i_req_rd, i_req_wd, i_issue_en, i_issue_rd, i_rs1, i_rs2,
    input  o_req_ready, o_Wen, o_Wnum, o_Wd, o_hazard
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port plus busy scoreboard / hazard flag.
// Optional macro WB_BYPASS_EN adds writeback forwarding and masks matching RAW terms.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int W  = `WORD_SIZE;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic           wen_q, wen_d;
  logic [4:0]     wnum_q, wnum_d;
  logic [W-1:0]   wd_q, wd_d;
  logic [31:0]    busy_q, busy_d;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               grant_any;
  logic [4:0]         sel_rd;
  logic [W-1:0]       sel_wd;
  logic               wen_out;
  logic               raw1, raw2, waw;
  logic               hazard;
  logic               issue_set;
  logic               fwd1, fwd2;

  // Round-robin search beginning one past the last winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!grant_any && bus.i_req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = PW'(idx);
      end
    end
    if (i_rst) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_rd = bus.i_req_rd[32'(grant_idx)*5 +: 5];
    sel_wd = bus.i_req_wd[32'(grant_idx)*W +: W];
  end

  always_comb begin
    ptr_d  = ptr_q;
    wen_d  = 1'b0;
    wnum_d = wnum_q;
    wd_d   = wd_q;
    if (grant_any) begin
      ptr_d  = grant_idx;
      wen_d  = (sel_rd != 5'd0);
      wnum_d = sel_rd;
      wd_d   = sel_wd;
    end
  end

  // A write already registered is suppressed if reset lands in its cycle.
  assign wen_out = wen_q & ~i_rst;

  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`ifdef WB_BYPASS_EN
    fwd1 = wen_out && (wnum_q == bus.i_rs1) && (wnum_q != 5'd0);
    fwd2 = wen_out && (wnum_q == bus.i_rs2) && (wnum_q != 5'd0);
`endif
    raw1      = busy_q[bus.i_rs1] & ~fwd1;
    raw2      = busy_q[bus.i_rs2] & ~fwd2;
    waw       = busy_q[bus.i_issue_rd];
    hazard    = bus.i_issue_en & (raw1 | raw2 | waw);
    issue_set = bus.i_issue_en & ~hazard & (bus.i_issue_rd != 5'd0);
  end

  // Clear first, then set, so a newer producer on the same index survives.
  always_comb begin
    busy_d = busy_q;
    if (wen_out) begin
      busy_d[wnum_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[bus.i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q  <= PW'(NUM_REQ - 1);
      wen_q  <= 1'b0;
      wnum_q <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wen_q  <= wen_d;
      wnum_q <= wnum_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_Wen       = wen_out;
  assign bus.o_Wnum      = wnum_q;
  assign bus.o_Wd        = wd_q;
  assign bus.o_hazard    = hazard;
`ifdef WB_BYPASS_EN
  assign bus.o_fwd1_en   = fwd1;
  assign bus.o_fwd2_en   = fwd2;
  assign bus.o_fwd_data  = wd_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (NUM_REQ=3) with hand-written
// sequences for RAW retirement, set/clear collision and reset during a pending write.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_regfile_wb_arbiter;
  localparam int W = `WORD_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(3)) bus ();
  regfile_wb_arbiter #(.NUM_REQ(3)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // External register file model.
  logic [W-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (bus.o_Wen) rf[bus.o_Wnum] <= bus.o_Wd;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic [2:0] valid;
    logic [4:0] rd0, rd1, rd2;
    logic       ie;
    logic [4:0] ird, rs1, rs2;
    logic [2:0] ready;
    logic       wen;
    logic [4:0] wnum;
    logic       haz;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [W-1:0] wd_of(input int k, input logic [4:0] rd);
    logic [31:0] t;
    t = ((32'(k) + 32'd1) << 28) | 32'(rd);
    return W'(t);
  endfunction

  function automatic vec_t mk(input logic r, input logic [2:0] v,
                              input logic [4:0] a0, a1, a2,
                              input logic ie, input logic [4:0] ird, s1, s2,
                              input logic [2:0] rdy, input logic we,
                              input logic [4:0] wn, input logic hz);
    vec_t x;
    x.rst = r; x.valid = v; x.rd0 = a0; x.rd1 = a1; x.rd2 = a2;
    x.ie = ie; x.ird = ird; x.rs1 = s1; x.rs2 = s2;
    x.ready = rdy; x.wen = we; x.wnum = wn; x.haz = hz;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] v,
                       input logic [4:0] a0, a1, a2,
                       input logic ie, input logic [4:0] ird, s1, s2);
    rst             = r;
    bus.i_req_valid = v;
    bus.i_req_rd    = {a2, a1, a0};
    bus.i_req_wd    = {wd_of(2, a2), wd_of(1, a1), wd_of(0, a0)};
    bus.i_issue_en  = ie;
    bus.i_issue_rd  = ird;
    bus.i_rs1       = s1;
    bus.i_rs2       = s2;
  endtask

  initial begin
    logic [W-1:0] exp_wd;
    exp_wd = '0;

    // Reset and round robin (ptr resets to 2, so req0 wins first)
    vecs[0]  = mk(1, 3'b111, 1, 2, 3, 1, 7, 5, 6, 3'b000, 0, 0, 0);
    vecs[1]  = mk(1, 3'b111, 1, 2, 3, 1, 7, 5, 6, 3'b000, 0, 0, 0);
    vecs[2]  = mk(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    vecs[3]  = mk(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b010, 1, 1, 0);
    vecs[4]  = mk(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b100, 1, 2, 0);
    vecs[5]  = mk(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b001, 1, 3, 0);
    vecs[6]  = mk(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b010, 1, 1, 0);
    vecs[7]  = mk(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b100, 1, 2, 0);
    vecs[8]  = mk(0, 3'b000, 1, 2, 3, 0, 0, 0, 0, 3'b000, 1, 3, 0);
    // Scoreboard: issue rd=5, then RAW via rs1 and WAW via rd
    vecs[9]  = mk(0, 3'b000, 1, 2, 3, 1, 5, 0, 0, 3'b000, 0, 3, 0);
    vecs[10] = mk(0, 3'b000, 1, 2, 3, 1, 0, 5, 0, 3'b000, 0, 3, 1);
    vecs[11] = mk(0, 3'b000, 1, 2, 3, 1, 5, 0, 0, 3'b000, 0, 3, 1);
    // x0 write: granted, no o_Wen; issuing rd=0 never sets busy
    vecs[12] = mk(0, 3'b001, 0, 2, 3, 1, 0, 0, 0, 3'b001, 0, 3, 0);
    vecs[13] = mk(0, 3'b000, 0, 2, 3, 1, 0, 0, 6, 3'b000, 0, 0, 0);
    vecs[14] = mk(0, 3'b000, 0, 2, 3, 1, 0, 0, 5, 3'b000, 0, 0, 1);

    drive(1, 3'b111, 1, 2, 3, 1, 7, 5, 6);
    @(posedge clk);

    for (int i = 0; i < 15; i++) begin
      #1;
      drive(vecs[i].rst, vecs[i].valid, vecs[i].rd0, vecs[i].rd1, vecs[i].rd2,
            vecs[i].ie, vecs[i].ird, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      check($sformatf("v%0d.ready", i), 64'(bus.o_req_ready), 64'(vecs[i].ready));
      check($sformatf("v%0d.wen", i),   64'(bus.o_Wen),       64'(vecs[i].wen));
      check($sformatf("v%0d.wnum", i),  64'(bus.o_Wnum),      64'(vecs[i].wnum));
      check($sformatf("v%0d.wd", i),    64'(bus.o_Wd),        64'(exp_wd));
      check($sformatf("v%0d.hazard", i), 64'(bus.o_hazard),   64'(vecs[i].haz));
      if (vecs[i].rst) exp_wd = '0;
      else if (vecs[i].ready[0]) exp_wd = wd_of(0, vecs[i].rd0);
      else if (vecs[i].ready[1]) exp_wd = wd_of(1, vecs[i].rd1);
      else if (vecs[i].ready[2]) exp_wd = wd_of(2, vecs[i].rd2);
      @(posedge clk);
    end

    // RAW retirement: req1 writes rd=5 while rs1=5 is queried
    #1;
    drive(0, 3'b010, 0, 5, 0, 1, 0, 5, 0);
    bus.i_req_wd[1*W +: W] = W'(32'hDEADBEEF);
    @(negedge clk);
    check("raw.N.ready", 64'(bus.o_req_ready), 64'(3'b010));
    check("raw.N.hazard", 64'(bus.o_hazard), 64'd1);
    @(posedge clk); #1;
    drive(0, 3'b000, 0, 0, 0, 1, 0, 5, 0);
    @(negedge clk);
    check("raw.N1.wen", 64'(bus.o_Wen), 64'd1);
    check("raw.N1.wnum", 64'(bus.o_Wnum), 64'd5);
    check("raw.N1.wd", 64'(bus.o_Wd), 64'(W'(32'hDEADBEEF)));
`ifdef WB_BYPASS_EN
    check("raw.N1.hazard", 64'(bus.o_hazard), 64'd0);
    check("raw.N1.fwd1", 64'(bus.o_fwd1_en), 64'd1);
    check("raw.N1.fwd2", 64'(bus.o_fwd2_en), 64'd0);
    check("raw.N1.fwd_data", 64'(bus.o_fwd_data), 64'(W'(32'hDEADBEEF)));
`else
    check("raw.N1.hazard", 64'(bus.o_hazard), 64'd1);
`endif
    @(posedge clk); #1;
    drive(0, 3'b000, 0, 0, 0, 1, 0, 5, 0);
    @(negedge clk);
    check("raw.N2.hazard", 64'(bus.o_hazard), 64'd0);
    check("raw.N2.wen", 64'(bus.o_Wen), 64'd0);
    check("raw.N2.rf5", 64'(rf[5]), 64'(W'(32'hDEADBEEF)));
    @(posedge clk);

    // Set/clear collision on x9: write retires in the same cycle rd=9 issues
    #1;
    drive(0, 3'b001, 9, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("col.A.ready", 64'(bus.o_req_ready), 64'(3'b001));
    @(posedge clk); #1;
    drive(0, 3'b000, 9, 0, 0, 1, 9, 0, 0);
    @(negedge clk);
    check("col.B.wen", 64'(bus.o_Wen), 64'd1);
    check("col.B.wnum", 64'(bus.o_Wnum), 64'd9);
    check("col.B.wd", 64'(bus.o_Wd), 64'(wd_of(0, 5'd9)));
    check("col.B.hazard", 64'(bus.o_hazard), 64'd0);
    @(posedge clk); #1;
    drive(0, 3'b000, 0, 0, 0, 1, 0, 9, 0);
    @(negedge clk);
    check("col.C.hazard", 64'(bus.o_hazard), 64'd1);
    @(posedge clk);

    // Reset lands in the cycle a write to x12 is presented
    #1;
    drive(0, 3'b000, 0, 0, 0, 1, 12, 0, 0);
    @(negedge clk);
    check("rst.D.hazard", 64'(bus.o_hazard), 64'd0);
    @(posedge clk); #1;
    drive(0, 3'b100, 0, 0, 12, 0, 0, 0, 0);
    @(negedge clk);
    check("rst.N.ready", 64'(bus.o_req_ready), 64'(3'b100));
    @(posedge clk); #1;
    drive(1, 3'b000, 0, 0, 0, 1, 0, 12, 0);
    @(negedge clk);
    check("rst.N1.wen", 64'(bus.o_Wen), 64'd0);
    check("rst.N1.ready", 64'(bus.o_req_ready), 64'd0);
`ifdef WB_BYPASS_EN
    check("rst.N1.fwd1", 64'(bus.o_fwd1_en), 64'd0);
`endif
    @(posedge clk); #1;
    drive(0, 3'b111, 1, 2, 3, 1, 0, 12, 0);
    @(negedge clk);
    check("rst.N2.hazard", 64'(bus.o_hazard), 64'd0);
    check("rst.N2.wen", 64'(bus.o_Wen), 64'd0);
    check("rst.N2.rf12", 64'(rf[12]), 64'd0);
    check("rst.N2.ready", 64'(bus.o_req_ready), 64'(3'b001));
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
